// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the pipelined adder datapath.
// The optional overflow output is enabled by defining PIPELINED_ADDER_OVF_EN.
package adder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEG_W = 4;

    function automatic int stages(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    // Control part of a pipeline stage record. The partial sum and the pending
    // a/b slices shrink and grow from stage to stage, so each stage declares
    // those beside this record at its own exact width.
    typedef struct packed {
        logic valid;
        logic sub;
        logic carry;
    } stage_ctrl_t;

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG_W-bit ripple slice of full-adder cells; c_msb is the carry
// into the slice's top bit, used for signed overflow (PIPELINED_ADDER_OVF_EN).
module adder_segment #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [SEG_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SEG_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[SEG_W];
    assign c_msb = c[SEG_W-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract pipelined SEG_W bits per stage with valid/ready on both
// sides. Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow port ovf.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = stages(WIDTH, SEG_W);

    logic adv;

    // The whole pipe moves in lockstep; it only freezes when the final result is refused.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int IN_W   = WIDTH - k * SEG_W;
        localparam int HI_W   = IN_W - SEG_W;
        localparam int DONE_W = (k + 1) * SEG_W;

        logic [IN_W-1:0]   src_a;
        logic [IN_W-1:0]   src_b;
        logic              src_ci;
        logic              src_valid;
        logic              src_sub;
        logic [DONE_W-1:0] nxt_psum;
        logic [SEG_W-1:0]  seg_s;
        logic              seg_co;
        logic              seg_cmsb;

        stage_ctrl_t       ctrl;
        logic [DONE_W-1:0] psum;

        // Stage 0 applies the subtract inversion and forces the carry-in to 1 for sub.
        if (k == 0) begin : g_src
            assign src_a     = a;
            assign src_b     = sub ? ~b : b;
            assign src_ci    = sub | cin;
            assign src_valid = in_valid;
            assign src_sub   = sub;
            assign nxt_psum  = seg_s;
        end else begin : g_src
            assign src_a     = stg[k-1].g_pend.pa;
            assign src_b     = stg[k-1].g_pend.pb;
            assign src_ci    = stg[k-1].ctrl.carry;
            assign src_valid = stg[k-1].ctrl.valid;
            assign src_sub   = stg[k-1].ctrl.sub;
            assign nxt_psum  = {seg_s, stg[k-1].psum};
        end

        adder_segment #(.SEG_W(SEG_W)) u_seg (
            .a     (src_a[SEG_W-1:0]),
            .b     (src_b[SEG_W-1:0]),
            .ci    (src_ci),
            .s     (seg_s),
            .co    (seg_co),
            .c_msb (seg_cmsb)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                ctrl <= '0;
                psum <= '0;
            end else if (adv) begin
                ctrl <= '{valid: src_valid, sub: src_sub, carry: seg_co};
                psum <= nxt_psum;
            end
        end

        // Operand slices not yet consumed ride along to the stages that will add them.
        if (HI_W > 0) begin : g_pend
            logic [HI_W-1:0] pa;
            logic [HI_W-1:0] pb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pa <= '0;
                    pb <= '0;
                end else if (adv) begin
                    pa <= src_a[IN_W-1:SEG_W];
                    pb <= src_b[IN_W-1:SEG_W];
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
`ifdef PIPELINED_ADDER_OVF_EN
            logic ovf_q;
            logic unused_sub;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= seg_cmsb ^ seg_co;
                end
            end

            assign unused_sub = ctrl.sub;
`else
            logic unused_last;

            assign unused_last = seg_cmsb ^ ctrl.sub;
`endif
        end else begin : g_mid
            logic unused_cmsb;

            assign unused_cmsb = seg_cmsb;
        end
    end

    assign out_valid = stg[STAGES-1].ctrl.valid;
    assign cout      = stg[STAGES-1].ctrl.carry;
    assign sum       = stg[STAGES-1].psum;
`ifdef PIPELINED_ADDER_OVF_EN
    assign ovf       = stg[STAGES-1].g_last.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: dut0 is the 2-stage build, dut1 the 1-stage build.
// Checks ovf as well when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         lat;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] a         [2];
    logic [7:0] b         [2];
    logic       cin       [2];
    logic       sub       [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] sum       [2];
    logic       cout      [2];
`ifdef PIPELINED_ADDER_OVF_EN
    logic       ovf       [2];
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   rand_ready [2];
    bit   done1 = 1'b0;

    pipelined_adder #(.WIDTH(8), .SEG_W(4)) u_dut0 (
        .clk       (clk),
        .rst       (rst[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .a         (a[0]),
        .b         (b[0]),
        .cin       (cin[0]),
        .sub       (sub[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .sum       (sum[0]),
        .cout      (cout[0])
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .ovf       (ovf[0])
`endif
    );

    pipelined_adder #(.WIDTH(8), .SEG_W(8)) u_dut1 (
        .clk       (clk),
        .rst       (rst[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .a         (a[1]),
        .b         (b[1]),
        .cin       (cin[1]),
        .sub       (sub[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .sum       (sum[1]),
        .cout      (cout[1])
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .ovf       (ovf[1])
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [7:0] s, input logic c, input logic o, input int lat);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        e.lat  = lat;
        e.cyc  = 0;
        return e;
    endfunction

    // Reference arithmetic: 9-bit sum of a and the (possibly inverted) b.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
        logic [7:0] yy;
        logic [8:0] r;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {8'd0, (s | c)};
        return mk(r[7:0], r[8], (x[7] == yy[7]) && (r[7] != x[7]), 0);
    endfunction

    task automatic checkOutput(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL dut%0d %s: got 0x%0h, expected 0x%0h", d, name, act, exp);
        end
    endtask

    task automatic checkReset(input int d);
        checkOutput("rst_out_valid", d, 32'(out_valid[d]), 32'd0);
        checkOutput("rst_sum", d, 32'(sum[d]), 32'd0);
        checkOutput("rst_cout", d, 32'(cout[d]), 32'd0);
        checkOutput("rst_in_ready", d, 32'(in_ready[d]), 32'd1);
`ifdef PIPELINED_ADDER_OVF_EN
        checkOutput("rst_ovf", d, 32'(ovf[d]), 32'd0);
`endif
    endtask

    // Holds the operands until accepted and pushes the expectation at the transfer.
    task automatic applyStimulus(input int d, input logic [7:0] x, input logic [7:0] y,
                                 input logic c, input logic s, input exp_t e);
        bit got = 1'b0;
        a[d] = x;
        b[d] = y;
        cin[d] = c;
        sub[d] = s;
        in_valid[d] = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                e.cyc = cyc;
                if (d == 0) q0.push_back(e);
                else q1.push_back(e);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL dut%0d accept_timeout: in_ready low for 200 cycles, expected 1", d);
        end
    endtask

    task automatic idle(input int d, input int n);
        in_valid[d] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitorStep(input int d);
        exp_t e;
        int   qn;
        qn = (d == 0) ? q0.size() : q1.size();
        if (rst[d]) return;
        if (out_valid[d] && !out_ready[d] && qn > 0) begin
            e = (d == 0) ? q0[0] : q1[0];
            checkOutput("stall_sum", d, 32'(sum[d]), 32'(e.sum));
            checkOutput("stall_cout", d, 32'(cout[d]), 32'(e.cout));
        end
        if (out_valid[d] && out_ready[d]) begin
            if (qn == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL dut%0d unexpected_output: got sum 0x%0h, expected no output", d, sum[d]);
            end else begin
                if (d == 0) e = q0.pop_front();
                else e = q1.pop_front();
                checkOutput("sum", d, 32'(sum[d]), 32'(e.sum));
                checkOutput("cout", d, 32'(cout[d]), 32'(e.cout));
`ifdef PIPELINED_ADDER_OVF_EN
                checkOutput("ovf", d, 32'(ovf[d]), 32'(e.ovf));
`endif
                if (e.lat > 0) checkOutput("latency", d, 32'(cyc - e.cyc), 32'(e.lat));
            end
        end
    endtask

    always @(negedge clk) begin
        monitorStep(0);
        monitorStep(1);
    end

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rand_ready[d]) out_ready[d] = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic drain(input int d);
        for (int i = 0; i < 100 && ((d == 0) ? q0.size() : q1.size()) > 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_left", d, 32'((d == 0) ? q0.size() : q1.size()), 32'd0);
    endtask

    task automatic randomRun(input int d, input int n);
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
        logic       s;
        rand_ready[d] = 1'b1;
        for (int i = 0; i < n; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            c = 1'($urandom);
            s = 1'($urandom);
            applyStimulus(d, x, y, c, s, model(x, y, c, s));
            if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
        end
        rand_ready[d] = 1'b0;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b1;
        drain(d);
    endtask

    // Single-stage build: same arithmetic, one cycle of latency.
    initial begin
        rst[1] = 1'b1;
        in_valid[1] = 1'b0;
        out_ready[1] = 1'b1;
        a[1] = '0;
        b[1] = '0;
        cin[1] = 1'b0;
        sub[1] = 1'b0;
        rand_ready[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkReset(1);
        rst[1] = 1'b0;
        applyStimulus(1, 8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0, 1));
        applyStimulus(1, 8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b1, 1'b1, 1));
        applyStimulus(1, 8'h05, 8'h07, 1'b0, 1'b1, mk(8'hFE, 1'b0, 1'b0, 1));
        idle(1, 2);
        randomRun(1, 300);
        done1 = 1'b1;
    end

    initial begin
        rst[0] = 1'b1;
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        a[0] = '0;
        b[0] = '0;
        cin[0] = 1'b0;
        sub[0] = 1'b0;
        rand_ready[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkReset(0);
        rst[0] = 1'b0;

        applyStimulus(0, 8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0, 2));
        applyStimulus(0, 8'h05, 8'h07, 1'b0, 1'b1, mk(8'hFE, 1'b0, 1'b0, 2));
        applyStimulus(0, 8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b1, 1'b1, 2));
        applyStimulus(0, 8'h10, 8'h01, 1'b1, 1'b1, mk(8'h0F, 1'b1, 1'b0, 2));
        applyStimulus(0, 8'h7F, 8'h00, 1'b1, 1'b0, mk(8'h80, 1'b0, 1'b1, 2));
        applyStimulus(0, 8'h0F, 8'h01, 1'b0, 1'b0, mk(8'h10, 1'b0, 1'b0, 2));
        idle(0, 3);

        applyStimulus(0, 8'h10, 8'h01, 1'b0, 1'b0, mk(8'h11, 1'b0, 1'b0, 2));
        applyStimulus(0, 8'h20, 8'h02, 1'b0, 1'b0, mk(8'h22, 1'b0, 1'b0, 2));
        applyStimulus(0, 8'h30, 8'h03, 1'b0, 1'b0, mk(8'h33, 1'b0, 1'b0, 2));
        applyStimulus(0, 8'h40, 8'h04, 1'b0, 1'b0, mk(8'h44, 1'b0, 1'b0, 2));
        idle(0, 4);

        // Backpressure: fill the pipe with the sink stalled, then release.
        out_ready[0] = 1'b0;
        applyStimulus(0, 8'h12, 8'h34, 1'b0, 1'b0, mk(8'h46, 1'b0, 1'b0, 0));
        applyStimulus(0, 8'hA0, 8'h70, 1'b0, 1'b0, mk(8'h10, 1'b1, 1'b0, 0));
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 0, 32'(in_ready[0]), 32'd0);
            checkOutput("bp_out_valid", 0, 32'(out_valid[0]), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready[0] = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", 0, 32'(in_ready[0]), 32'd1);
        idle(0, 4);
        checkOutput("bp_left", 0, 32'(q0.size()), 32'd0);

        // Reset one cycle after accepting 0x0F+0x01: the 0x10 must never appear.
        applyStimulus(0, 8'h0F, 8'h01, 1'b0, 1'b0, mk(8'h10, 1'b0, 1'b0, 2));
        rst[0] = 1'b1;
        q0.delete();
        @(posedge clk);
        #1;
        checkReset(0);
        rst[0] = 1'b0;
        idle(0, 6);

        randomRun(0, 1000);

        for (int i = 0; i < 20000 && !done1; i++) @(posedge clk);
        if (!done1) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL dut1 finish_timeout: done 0, expected 1");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
